// File: rtl/soft_clock_pkg.sv
// soft_clock_pkg: command nibbles, status codes and FSM states shared by the soft clock sequencer and gate
package soft_clock_pkg;

    localparam logic [3:0] CLOCK_ENABLE  = 4'b1010;
    localparam logic [3:0] CLOCK_DISABLE = 4'b0101;

    typedef enum logic [1:0] {ST_OK, ST_ERR, ST_TOUT, ST_QFAIL} status_e;

    typedef enum logic [2:0] {IDLE, QUIESCE, WRITE, GAP, RESP} state_e;

    function automatic logic [3:0] cmd_nibble(input logic enable);
        return enable ? CLOCK_ENABLE : CLOCK_DISABLE;
    endfunction

endpackage

// File: rtl/soft_clock_sequencer_if.sv
// soft_clock_sequencer_if: request, quiesce, gate-write and status signals of the sequencer
//   master: sequencer side (takes requests/busy/gate responses, drives write word and status)
//   slave : environment side (migration controller, reconfigurable IP and clock gate)
interface soft_clock_sequencer_if #(parameter int C_SIPIF_DWIDTH = 32);
    logic                          Req_Valid;
    logic                          Req_Enable;
    logic                          Req_Ready;
    logic                          IP2Seq_Busy;
    logic                          Seq2Clk_WrCE;
    logic [0:C_SIPIF_DWIDTH-1]     Seq2Clk_Data;
    logic [0:C_SIPIF_DWIDTH/8-1]   Seq2Clk_BE;
    logic                          Clk2Bus_WrAck;
    logic                          Clk2Bus_Error;
    logic                          Seq_Done;
    logic [1:0]                    Seq_Status;
    logic                          Seq_ClkOn;

    modport master (
        input  Req_Valid, Req_Enable, IP2Seq_Busy, Clk2Bus_WrAck, Clk2Bus_Error,
        output Req_Ready, Seq2Clk_WrCE, Seq2Clk_Data, Seq2Clk_BE, Seq_Done, Seq_Status, Seq_ClkOn
    );

    modport slave (
        output Req_Valid, Req_Enable, IP2Seq_Busy, Clk2Bus_WrAck, Clk2Bus_Error,
        input  Req_Ready, Seq2Clk_WrCE, Seq2Clk_Data, Seq2Clk_BE, Seq_Done, Seq_Status, Seq_ClkOn
    );
endinterface

// File: rtl/soft_clock_sequencer_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and a flag raised when the count equals MAX
//   Bus2IP_Clk/Bus2IP_Reset: clock and sync active-high reset
//   clr: clear to zero (wins over inc); inc: count up, holds at MAX; at_max: count == MAX
module sat_counter #(
    parameter int MAX = 1
) (
    input  logic Bus2IP_Clk,
    input  logic Bus2IP_Reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);
    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] TOP = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset || clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + 1'b1;
    end

    assign at_max = cnt == TOP;
endmodule

// File: rtl/soft_clock_sequencer.sv
// soft_clock_sequencer: turns clock enable/disable requests into one acknowledged IPIF write to the soft clock gate
//   Bus2IP_Clk/Bus2IP_Reset: sole clock and sync active-high reset
//   bus (master): Req_Valid/Req_Enable/Req_Ready request handshake, IP2Seq_Busy quiesce input,
//                 Seq2Clk_WrCE/Data/BE gate write, Clk2Bus_WrAck/Error gate response,
//                 Seq_Done/Seq_Status completion pulse, Seq_ClkOn recorded gate state
module soft_clock_sequencer
    import soft_clock_pkg::*;
#(
    parameter int C_SIPIF_DWIDTH   = 32,
    parameter int C_TOUT_CYCLES    = 16,
    parameter int C_QUIESCE_CYCLES = 64,
    parameter int C_MAX_RETRY      = 2
) (
    input  logic                 Bus2IP_Clk,
    input  logic                 Bus2IP_Reset,
    soft_clock_sequencer_if.master bus
);
    state_e  state, state_n;
    status_e st_n;
    logic    en_q, en_n;
    logic    t_last, q_last, r_last, retry;
    logic [0:C_SIPIF_DWIDTH-1] word;

    // Timeout counter runs every WRITE cycle; at_max marks the last allowed cycle of an attempt.
    sat_counter #(.MAX(C_TOUT_CYCLES - 1)) u_tout (
        .Bus2IP_Clk  (Bus2IP_Clk),
        .Bus2IP_Reset(Bus2IP_Reset),
        .clr         (state != WRITE),
        .inc         (state == WRITE),
        .at_max      (t_last)
    );

    sat_counter #(.MAX(C_QUIESCE_CYCLES - 1)) u_quiesce (
        .Bus2IP_Clk  (Bus2IP_Clk),
        .Bus2IP_Reset(Bus2IP_Reset),
        .clr         (state != QUIESCE),
        .inc         (state == QUIESCE && bus.IP2Seq_Busy),
        .at_max      (q_last)
    );

    sat_counter #(.MAX(C_MAX_RETRY)) u_retry (
        .Bus2IP_Clk  (Bus2IP_Clk),
        .Bus2IP_Reset(Bus2IP_Reset),
        .clr         (state == IDLE),
        .inc         (retry),
        .at_max      (r_last)
    );

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        st_n    = ST_OK;
        en_n    = en_q;
        retry   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Req_Valid) begin
                    en_n    = bus.Req_Enable;
                    state_n = bus.Req_Enable ? WRITE : QUIESCE;
                end
            end
            QUIESCE: begin
                if (!bus.IP2Seq_Busy)
                    state_n = WRITE;
                else if (q_last) begin
                    state_n = RESP;
                    st_n    = ST_QFAIL;
                end
            end
            WRITE: begin
                // Ack wins when the gate reports both in the same cycle.
                if (bus.Clk2Bus_WrAck)
                    state_n = RESP;
                else if (bus.Clk2Bus_Error || t_last) begin
                    retry   = !r_last;
                    state_n = r_last ? RESP : GAP;
                    st_n    = bus.Clk2Bus_Error ? ST_ERR : ST_TOUT;
                end
            end
            GAP:     state_n = WRITE;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Built from en_n so the word is correct on the very edge that accepts an enable.
    assign word = {{(C_SIPIF_DWIDTH-4){1'b0}}, cmd_nibble(en_n)};

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            en_q             <= 1'b0;
            bus.Seq2Clk_WrCE <= 1'b0;
            bus.Seq2Clk_Data <= '0;
            bus.Seq2Clk_BE   <= '0;
            bus.Seq_Done     <= 1'b0;
            bus.Seq_Status   <= ST_OK;
            bus.Seq_ClkOn    <= 1'b1;
        end else begin
            en_q             <= en_n;
            bus.Seq2Clk_WrCE <= state_n == WRITE;
            bus.Seq2Clk_Data <= (state_n == WRITE) ? word : '0;
            bus.Seq2Clk_BE   <= (state_n == WRITE) ? '1 : '0;
            bus.Seq_Done     <= state_n == RESP;
            bus.Seq_Status   <= (state_n == RESP) ? st_n : ST_OK;
            if (state == WRITE && bus.Clk2Bus_WrAck)
                bus.Seq_ClkOn <= en_q;
        end
    end

    assign bus.Req_Ready = state == IDLE;
endmodule

// File: tb/tb_soft_clock_sequencer.sv
// tb_soft_clock_sequencer: directed table, random requests against a transaction-level model, and a mid-write reset
module tb_soft_clock_sequencer;
    localparam int DW = 32;
    localparam int T  = 16;
    localparam int Q  = 64;
    localparam int R  = 2;

    logic Bus2IP_Clk = 1'b0;
    logic Bus2IP_Reset = 1'b1;
    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    soft_clock_sequencer_if #(.C_SIPIF_DWIDTH(DW)) bus ();

    soft_clock_sequencer #(
        .C_SIPIF_DWIDTH(DW), .C_TOUT_CYCLES(T), .C_QUIESCE_CYCLES(Q), .C_MAX_RETRY(R)
    ) dut (
        .Bus2IP_Clk  (Bus2IP_Clk),
        .Bus2IP_Reset(Bus2IP_Reset),
        .bus         (bus.master)
    );

    // Gate model: per attempt a response kind (bit0 ack, bit1 error, 0 silent) after g_dly strobe cycles.
    logic [1:0] g_kind [8];
    int         g_dly  [8];
    logic [2:0] g_att = '0;
    int         g_run = 0;

    assign bus.Clk2Bus_WrAck = bus.Seq2Clk_WrCE && g_run == g_dly[g_att] && g_kind[g_att][0];
    assign bus.Clk2Bus_Error = bus.Seq2Clk_WrCE && g_run == g_dly[g_att] && g_kind[g_att][1];

    int n_chk = 0;
    int n_pass = 0;
    bit exp_on = 1'b1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    // Transaction-level expectation: attempt lengths, gaps and outcome from the gate program.
    task automatic model(input bit en, input int b, output int st, output int np, output int len0, output int done);
        int total;
        int len;
        st = 0; np = 0; len0 = 0; total = 0;
        if (!en && b >= Q) begin
            st = 3;
            done = Q;
            return;
        end
        for (int i = 0; i <= R; i++) begin
            len = (g_kind[i] != 0 && g_dly[i] < T) ? g_dly[i] + 1 : T;
            total += len;
            np = i + 1;
            if (i == 0) len0 = len;
            st = g_kind[i][0] && g_dly[i] < T ? 0 : (g_kind[i][1] && g_dly[i] < T ? 1 : 2);
            if (st == 0 || i == R) break;
            total += 1;
        end
        done = (en ? 0 : b + 1) + total;
    endtask

    task automatic do_req(input string nm, input bit en, input int b, input bit noise,
                          input int e_st, input int e_np, input int e_len0, input int e_done, input bit e_on);
        int np = 0, len0 = 0, done_c = -1, ndone = 0, st = -1, bad_data = 0, bad_gap = 0, last_w = -10;
        bit prev_w = 1'b0;
        chk({nm, " ready"}, int'(bus.Req_Ready), 1);
        bus.Req_Valid = 1'b1;
        bus.Req_Enable = en;
        bus.IP2Seq_Busy = b > 0;
        @(posedge Bus2IP_Clk); #1;
        for (int c = 0; c < 400; c++) begin
            bus.IP2Seq_Busy = c < b;
            if (bus.Seq2Clk_WrCE) begin
                if (!prev_w) begin
                    g_att = 3'(np);
                    g_run = 0;
                    np++;
                    if (np > 1 && c - last_w != 2) bad_gap++;
                end else g_run++;
                if (np == 1) len0++;
                if (bus.Seq2Clk_Data != (en ? 32'h0000000A : 32'h00000005) || bus.Seq2Clk_BE != 4'hF) bad_data++;
                last_w = c;
            end
            prev_w = bus.Seq2Clk_WrCE;
            if (bus.Seq_Done) begin
                ndone++;
                if (done_c < 0) begin
                    done_c = c;
                    st = int'(bus.Seq_Status);
                end
            end
            bus.Req_Valid = noise && done_c < 0 && !bus.Seq_Done ? 1'($urandom % 2) : 1'b0;
            bus.Req_Enable = 1'($urandom % 2);
            if (done_c >= 0 && c >= done_c + 2) break;
            @(posedge Bus2IP_Clk); #1;
        end
        bus.IP2Seq_Busy = 1'b0;
        chk({nm, " status"}, st, e_st);
        chk({nm, " wrce_pulses"}, np, e_np);
        chk({nm, " first_pulse_len"}, len0, e_len0);
        chk({nm, " done_cycle"}, done_c, e_done);
        chk({nm, " done_count"}, ndone, 1);
        chk({nm, " clk_on"}, int'(bus.Seq_ClkOn), int'(e_on));
        chk({nm, " bad_data_cycles"}, bad_data, 0);
        chk({nm, " bad_gaps"}, bad_gap, 0);
    endtask

    typedef struct {
        bit en; int b;
        logic [1:0] k0; int d0; logic [1:0] k1; int d1; logic [1:0] k2; int d2;
        int st; int np; int len0; int done; bit on;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int st, np, len0, done, b, cnt;
        bit en;
        tbl[0] = '{1'b1,   0, 2'd1, 0,  2'd1, 0,  2'd1, 0, 0, 1, 1,  1, 1'b1};
        tbl[1] = '{1'b0,   5, 2'd1, 0,  2'd1, 0,  2'd1, 0, 0, 1, 1,  7, 1'b0};
        tbl[2] = '{1'b1,   0, 2'd2, 0,  2'd2, 0,  2'd2, 0, 1, 3, 1,  5, 1'b0};
        tbl[3] = '{1'b1,   0, 2'd0, 0,  2'd0, 0,  2'd0, 0, 2, 3, 16, 50, 1'b0};
        tbl[4] = '{1'b0, 100, 2'd1, 0,  2'd1, 0,  2'd1, 0, 3, 0, 0,  64, 1'b0};
        tbl[5] = '{1'b1,   0, 2'd3, 0,  2'd1, 0,  2'd1, 0, 0, 1, 1,  1, 1'b1};
        tbl[6] = '{1'b0,   0, 2'd2, 0,  2'd1, 3,  2'd1, 0, 0, 2, 1,  7, 1'b0};
        tbl[7] = '{1'b1,   0, 2'd0, 0,  2'd1, 15, 2'd1, 0, 0, 2, 16, 33, 1'b1};
        for (int i = 0; i < 8; i++) begin
            g_kind[i] = 2'd0;
            g_dly[i] = 0;
        end
        bus.Req_Valid = 1'b0;
        bus.Req_Enable = 1'b0;
        bus.IP2Seq_Busy = 1'b0;
        repeat (3) @(posedge Bus2IP_Clk);
        #1 Bus2IP_Reset = 1'b0;
        chk("reset ready", int'(bus.Req_Ready), 1);
        chk("reset wrce", int'(bus.Seq2Clk_WrCE), 0);
        chk("reset data", int'(bus.Seq2Clk_Data), 0);
        chk("reset be", int'(bus.Seq2Clk_BE), 0);
        chk("reset done", int'(bus.Seq_Done), 0);
        chk("reset status", int'(bus.Seq_Status), 0);
        chk("reset clk_on", int'(bus.Seq_ClkOn), 1);

        for (int i = 0; i < 8; i++) begin
            g_kind[0] = tbl[i].k0; g_dly[0] = tbl[i].d0;
            g_kind[1] = tbl[i].k1; g_dly[1] = tbl[i].d1;
            g_kind[2] = tbl[i].k2; g_dly[2] = tbl[i].d2;
            do_req($sformatf("vec%0d", i), tbl[i].en, tbl[i].b, 1'b0,
                   tbl[i].st, tbl[i].np, tbl[i].len0, tbl[i].done, tbl[i].on);
        end
        exp_on = tbl[7].on;

        for (int i = 0; i < 30; i++) begin
            en = 1'($urandom % 2);
            b = ($urandom % 4 == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 6));
            for (int k = 0; k < 8; k++) begin
                g_kind[k] = 2'($urandom % 4);
                g_dly[k] = int'($urandom_range(0, 18));
            end
            model(en, b, st, np, len0, done);
            if (st == 0) exp_on = en;
            do_req($sformatf("rnd%0d", i), en, b, 1'b1, st, np, len0, done, exp_on);
        end

        g_kind[0] = 2'd1; g_dly[0] = 0;
        do_req("pre_reset_disable", 1'b0, 0, 1'b0, 0, 1, 1, 2, 1'b0);

        for (int k = 0; k < 8; k++) g_kind[k] = 2'd0;
        bus.Req_Valid = 1'b1;
        bus.Req_Enable = 1'b1;
        @(posedge Bus2IP_Clk); #1;
        bus.Req_Valid = 1'b0;
        repeat (4) @(posedge Bus2IP_Clk);
        #1 chk("midwrite wrce_before_reset", int'(bus.Seq2Clk_WrCE), 1);
        Bus2IP_Reset = 1'b1;
        @(posedge Bus2IP_Clk); #1;
        Bus2IP_Reset = 1'b0;
        chk("midwrite wrce_after_reset", int'(bus.Seq2Clk_WrCE), 0);
        chk("midwrite ready_after_reset", int'(bus.Req_Ready), 1);
        chk("midwrite clk_on_after_reset", int'(bus.Seq_ClkOn), 1);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.Seq_Done || bus.Seq2Clk_WrCE) cnt++;
            @(posedge Bus2IP_Clk); #1;
        end
        chk("midwrite no_done_or_wrce", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
